// File: rtl/bitvec_reader.sv
// Bit-vector reader: captures a flag vector on load and emits the index of each set bit via valid/ready.
// Define BITVEC_READER_SKIP_EN to jump straight to the next set bit instead of scanning one bit per cycle.
module bitvec_reader #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] vec_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_par,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   vec_q, vec_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W:0]     ptr_inc;
    logic [WIDTH-1:0]   above;
    logic               ptr_top;
    logic               last_set;

    // One extra bit so ptr+1 at the top index shifts everything out instead of wrapping.
    assign ptr_inc  = {1'b0, ptr_q} + (IDX_W+1)'(1);
    assign above    = vec_q >> ptr_inc;
    assign last_set = ~|above;
    assign ptr_top  = (ptr_q == IDX_W'(WIDTH-1));

`ifdef BITVEC_READER_SKIP_EN
    logic [WIDTH-1:0] masked;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;

    always_comb begin
        masked  = vec_q & ~((WIDTH'(1) << ptr_q) - WIDTH'(1));
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (masked[i] && !hit) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    vec_d   = vec_in;
                    ptr_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
`ifdef BITVEC_READER_SKIP_EN
                if (hit) begin
                    ptr_d   = hit_idx;
                    state_d = EMIT;
                end else begin
                    state_d = DONE;
                end
`else
                if (vec_q[ptr_q]) begin
                    state_d = EMIT;
                end else if (ptr_top) begin
                    state_d = DONE;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
`endif
            end
            EMIT: begin
                if (out_ready) begin
`ifdef BITVEC_READER_SKIP_EN
                    if (ptr_top || last_set) begin
`else
                    if (ptr_top) begin
`endif
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + IDX_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q == EMIT);
        out_idx   = out_valid ? ptr_q : '0;
        out_par   = out_idx[0];
        out_last  = out_valid & last_set;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

endmodule

// File: tb/tb_bitvec_reader.sv
// Randomized bench for bitvec_reader: a queue-of-set-indices timing model predicts every cycle's outputs.
module tb_bitvec_reader;

    localparam int W      = 4;
    localparam int IW     = 2;
    localparam int BUDGET = 60;
`ifdef BITVEC_READER_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  vec_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_idx;
    logic          out_par;
    logic          out_last;
    logic          busy;
    logic          done;

    int vectors = 0;
    int miscompares = 0;

    bitvec_reader #(.WIDTH(W), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset), .load(load), .vec_in(vec_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_par(out_par), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: random ready, 1: ready always, 2: each item stalled 3 cycles
    task automatic run_scan(input logic [W-1:0] v, input int mode);
        int idxs[$];
        int nxt;
        int done_at;
        int pres;
        int prev;
        int n;
        bit rdy;
        bit finished;
        for (int i = 0; i < W; i++) if (v[i]) idxs.push_back(i);
        if (idxs.size() == 0) begin
            nxt = -1;
            done_at = SKIP ? 2 : W + 1;
        end else begin
            nxt = SKIP ? 2 : 2 + idxs[0];
            done_at = -1;
        end
        pres = 0;
        rdy = 1'b0;
        finished = 1'b0;
        load = 1'b1;
        vec_in = v;
        out_ready = 1'b0;
        for (n = 1; n <= BUDGET && !finished; n++) begin
            @(posedge clock);
            @(negedge clock);
            load = 1'b0;
            vec_in = W'($urandom);
            if (done_at >= 0 && n == done_at + 1) begin
                chk("idle_busy", 32'(busy), 0);
                chk("idle_done", 32'(done), 0);
                chk("idle_valid", 32'(out_valid), 0);
                finished = 1'b1;
            end else begin
                chk("busy", 32'(busy), 1);
                if (done_at >= 0 && n == done_at) begin
                    chk("done_pulse", 32'(done), 1);
                    chk("done_valid", 32'(out_valid), 0);
                end else begin
                    chk("done_low", 32'(done), 0);
                    if (idxs.size() > 0 && n >= nxt) begin
                        chk("valid", 32'(out_valid), 1);
                        chk("idx", 32'(out_idx), 32'(idxs[0]));
                        chk("par", 32'(out_par), 32'(idxs[0] % 2));
                        chk("last", 32'(out_last), 32'(idxs.size() == 1));
                        rdy = (mode == 1) ? 1'b1 : (mode == 2) ? (pres >= 3) : 1'($urandom);
                        pres++;
                        if (rdy) begin
                            prev = idxs.pop_front();
                            pres = 0;
                            if (idxs.size() > 0) nxt = SKIP ? n + 2 : n + 1 + (idxs[0] - prev);
                            else done_at = SKIP ? n + 1 : n + W - prev;
                        end
                    end else begin
                        chk("valid_low", 32'(out_valid), 0);
                        rdy = 1'($urandom);
                    end
                end
                // loads while busy must be ignored
                if (n == 1) begin
                    load = 1'b1;
                    vec_in = '1;
                end else begin
                    load = ($urandom % 3) == 0;
                end
            end
            out_ready = rdy;
        end
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL scan_timeout observed=no_idle expected=idle_within_%0d", BUDGET);
        end
        load = 1'b0;
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clock);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_idx", 32'(out_idx), 0);
        reset = 1'b0;
        @(negedge clock);

        run_scan(4'b1010, 1);
        run_scan(4'b0000, 1);
        run_scan(4'b0101, 2);
        run_scan(4'b1000, 1);
        run_scan(4'b1111, 1);

        // reset while presenting idx 1 of 4'b1111
        load = 1'b1;
        vec_in = 4'b1111;
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(posedge clock);
            @(negedge clock);
            load = 1'b0;
            if (out_valid && out_idx == 1) found = 1'b1;
            else out_ready = out_valid && out_idx == 0;
        end
        chk("reach_idx1", 32'(found), 1);
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_idx", 32'(out_idx), 0);
        chk("arst_par", 32'(out_par), 0);
        chk("arst_last", 32'(out_last), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_done", 32'(done), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        run_scan(4'b0010, 1);

        for (int i = 0; i < 40; i++) run_scan(W'($urandom), int'($urandom % 3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
